// File: rtl/event_wait_monitor.sv
// Waits for the ordered sequence: level high, then a later strobe rise, then a later event pulse.
// It also keeps saturating activity counters that run in every state.
module event_wait_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic             changes,
  input  logic             strobe,
  input  logic             evt,
  output logic             arrived,
  output logic             timeout,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] change_cnt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LVL  = 2'd1,
    S_WAIT_EDGE = 2'd2,
    S_WAIT_EVT  = 2'd3
  } state_t;

  localparam bit            TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}})) r = v + 1'b1;
    return r;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_arrived;
  logic             r_timeout;
  logic             r_busy;
  logic             r_changes_q;
  logic             r_strobe_q;
  logic [TO_W-1:0]  r_wait;
  logic [CNT_W-1:0] r_change_cnt;
  logic [CNT_W-1:0] r_rise_cnt;
  logic [CNT_W-1:0] r_evt_cnt;
  logic             w_arrived_nxt;
  logic             w_timeout_nxt;
  logic             w_change;
  logic             w_rise;

  assign w_change = changes ^ r_changes_q;
  assign w_rise   = strobe & ~r_strobe_q;

  // Next-state logic: abort beats completion, completion beats timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_arrived_nxt = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE:      if (arm && !abort) w_state_nxt = S_WAIT_LVL;
      S_WAIT_LVL:  if (changes)       w_state_nxt = S_WAIT_EDGE;
      S_WAIT_EDGE: if (w_rise)        w_state_nxt = S_WAIT_EVT;
      S_WAIT_EVT: begin
        if (evt) begin
          w_state_nxt   = S_IDLE;
          w_arrived_nxt = 1'b1;
        end
      end
      default:     w_state_nxt = S_IDLE;
    endcase
    if (r_state != S_IDLE) begin
      if (abort) begin
        w_state_nxt   = S_IDLE;
        w_arrived_nxt = 1'b0;
      end else if (!w_arrived_nxt && TO_EN && (r_wait == TO_LAST)) begin
        w_state_nxt   = S_IDLE;
        w_timeout_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_arrived <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arrived <= w_arrived_nxt;
      r_timeout <= w_timeout_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  // Held at zero in IDLE so it is already cleared on entry to WAIT_LVL
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE)) r_wait <= '0;
    else                            r_wait <= r_wait + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_changes_q  <= 1'b0;
      r_strobe_q   <= 1'b0;
      r_change_cnt <= '0;
      r_rise_cnt   <= '0;
      r_evt_cnt    <= '0;
    end else begin
      r_changes_q  <= changes;
      r_strobe_q   <= strobe;
      r_change_cnt <= sat_inc(r_change_cnt, w_change);
      r_rise_cnt   <= sat_inc(r_rise_cnt, w_rise);
      r_evt_cnt    <= sat_inc(r_evt_cnt, evt);
    end
  end

  assign arrived    = r_arrived;
  assign timeout    = r_timeout;
  assign busy       = r_busy;
  assign state      = r_state;
  assign change_cnt = r_change_cnt;
  assign rise_cnt   = r_rise_cnt;
  assign evt_cnt    = r_evt_cnt;

endmodule

// File: doc/event_wait_monitor.md
# event_wait_monitor

- Synthesizable, clocked responder to the stimulus side of the team's event/wait protocol.
- The stimulus side drives a level signal, a data strobe and one-cycle event pulses.
- This block arms on request and then waits for the ordered sequence "level high, then a later strobe rising edge, then a later event pulse", pulsing `arrived` when the sequence completes.
- It also keeps saturating activity counters for observation, and sits beside DUTs in lab designs as the hardware counterpart of wait-style bench checks.

## Interface
- `CNT_W`, 8: width of each activity counter.
- `TIMEOUT`, 0: maximum cycles spent in waiting states before abandoning; 0 disables the timeout.
- `TO_W`, 16: width of the wait-cycle counter; `TIMEOUT` must be < 2^`TO_W`.

Ports:
- `clk`  in  1  single clock; all inputs are synchronous to it.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  start a sequence wait; sampled only in IDLE.
- `abort`  in  1  return to IDLE from any state.
- `changes`  in  1  level input watched by the first wait stage.
- `strobe`  in  1  data strobe; its rising edges are detected internally.
- `evt`  in  1  event pulse; any high cycle counts as one event.
- `arrived`  out  1  one-cycle pulse when the sequence completes.
- `timeout`  out  1  one-cycle pulse when the wait is abandoned.
- `busy`  out  1  high in any waiting state.
- `state`  out  2  IDLE=0, WAIT_LVL=1, WAIT_EDGE=2, WAIT_EVT=3.
- `change_cnt`  out  `CNT_W`  number of cycles where `changes` differs from its previous sample.
- `rise_cnt`  out  `CNT_W`  number of `strobe` rising edges.
- `evt_cnt`  out  `CNT_W`  number of cycles with `evt` high.

## Operation
- Edge detection uses registered copies `changes_q` and `strobe_q`, both reset to 0.
  - A change is `changes != changes_q`.
  - A rise is `strobe & ~strobe_q`.
- Counters run in every state, including IDLE, and saturate at all-ones with no wrap. Only `rst` clears them.
- FSM, one transition per clock:
  - IDLE: `arm`=1 -> WAIT_LVL.
  - WAIT_LVL: `changes`=1 -> WAIT_EDGE. This is level-sensitive, so a level already high when arming passes on the first WAIT_LVL cycle.
  - WAIT_EDGE: a rise in a cycle spent in WAIT_EDGE -> WAIT_EVT. A rise in the same cycle that WAIT_LVL exits is not consumed.
  - WAIT_EVT: `evt`=1 in a cycle spent in WAIT_EVT -> IDLE with `arrived`. An `evt` in the cycle WAIT_EDGE exits is not consumed.
- Once past WAIT_LVL, `changes` falling is ignored.
- Timeout (`TIMEOUT`>0):
  - The wait counter clears on entry to WAIT_LVL and increments every waiting cycle.
  - In the cycle it equals `TIMEOUT`-1 without a completing transition -> IDLE with `timeout`.
- Precedence, highest first: `rst` > `abort` > completion > timeout.
  - An aborted wait pulses neither `arrived` nor `timeout`.
- `arm` while busy is ignored. `arm` together with `abort` in IDLE stays in IDLE.

## Timing
- Reset values:
  - `state`=IDLE.
  - `arrived`, `timeout`, `busy` = 0.
  - All counters = 0.
  - `changes_q`, `strobe_q`, and the wait counter = 0.
- All outputs are registered.
- `arrived` and `timeout` assert in the cycle after the qualifying input is sampled, coincident with `state` returning to 0.
- Counters update the cycle after the sampled activity.
- Minimum arm-to-arrived latency is 4 cycles:
  - arm sampled at edge N.
  - WAIT_LVL sampled at N+1 with `changes`=1.
  - Rise sampled at N+2.
  - `evt` sampled at N+3.
  - `arrived`=1 after edge N+3, i.e. during cycle N+4.
- Back-to-back: `arm` may be accepted in the cycle `arrived` is high, because the FSM is already in IDLE.
- `rst` mid-wait takes effect at the next edge. No pulse is emitted.

## Test plan
- Reset hold 2 cycles.
  - Expect: all outputs 0, `state`=0.
  - Toggle `changes` 0,1,0 over 3 cycles -> `change_cnt`=2. `state` stays 0 without `arm`.
- Arm with `changes`=0, raise `changes` at cycle 5, `strobe` rise at cycle 8, `evt` at cycle 12.
  - Expect `state` sequence 1,2,3,0.
  - Expect `arrived` one cycle high right after the `evt` cycle.
  - Expect `rise_cnt`=1, `evt_cnt`=1.
- Ordering:
  - `evt` pulse while in WAIT_EDGE -> ignored by the FSM, `evt_cnt` increments.
  - `strobe` held high through arm -> no rise, FSM stays in WAIT_EDGE until `strobe` falls and rises again.
- `TIMEOUT`=10, arm, never raise `changes` -> `timeout` pulses exactly 10 cycles after entering WAIT_LVL, `state`=0, `arrived` never high.
- Abort:
  - `abort` in WAIT_EVT -> IDLE next cycle, no pulses.
  - `rst` in WAIT_EDGE -> IDLE, counters 0.
  - Re-arm and complete normally.
- Saturation: `CNT_W`=4, pulse `evt` 20 times -> `evt_cnt` stops at 15. Back-to-back arm on the `arrived` cycle is accepted.
